// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between the fetch stage and decode. It stores
//   {pc, instr} pairs in a circular buffer with a valid/ready handshake on
//   both sides. Flush discards every entry when a branch or jump is taken.
//
//   Optional feature: define FETCH_QUEUE_BYPASS_EN to let an entry presented
//   to an empty queue go straight to decode in the same cycle, without
//   being stored. By default the macro is undefined and there is no
//   combinational path from In_* to Out_*.
//
// Parameters
//   DEPTH : number of entries; must be a power of two and at least 2
//   IW    : instruction word width
//   AW    : PC width
//
// Ports
//   CLK       in   clock; all state changes on the rising edge
//   Init      in   synchronous active-high reset; wins over Flush/push/pop
//   In_valid  in   fetch presents an entry
//   In_pc     in   PC of the presented entry
//   In_instr  in   instruction word of the presented entry
//   In_ready  out  the queue accepts an entry this cycle
//   Flush     in   discard all entries at the next edge
//   Out_valid out  the head entry is valid
//   Out_pc    out  PC of the head entry
//   Out_instr out  instruction of the head entry
//   Out_ready in   decode consumes the head entry this cycle
//   Count     out  number of stored entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int AW    = 16
) (
    input  logic                       CLK,
    input  logic                       Init,
    input  logic                       In_valid,
    input  logic [AW-1:0]              In_pc,
    input  logic [IW-1:0]              In_instr,
    output logic                       In_ready,
    input  logic                       Flush,
    output logic                       Out_valid,
    output logic [AW-1:0]              Out_pc,
    output logic [IW-1:0]              Out_instr,
    input  logic                       Out_ready,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    // Entry storage carries no reset; occupancy alone decides validity.
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0] instr_mem[DEPTH];

    logic full;
    logic stored_valid;
    logic bypass;
    logic push;
    logic pop;

    assign full         = (count_reg == CW'(DEPTH));
    assign stored_valid = (count_reg != '0) && !Flush && !Init;
    assign In_ready     = !full && !Flush && !Init;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue and decode is ready: hand the fetch entry straight through.
    assign bypass    = (count_reg == '0) && In_valid && Out_ready && !Flush && !Init;
    assign Out_valid = stored_valid || bypass;
    assign Out_pc    = bypass ? In_pc    : pc_mem[rd_ptr_reg];
    assign Out_instr = bypass ? In_instr : instr_mem[rd_ptr_reg];
`else
    assign bypass    = 1'b0;
    assign Out_valid = stored_valid;
    assign Out_pc    = pc_mem[rd_ptr_reg];
    assign Out_instr = instr_mem[rd_ptr_reg];
`endif

    // A bypassed entry is consumed in flight, so it is neither stored nor
    // popped from storage.
    assign push = In_valid && In_ready && !bypass;
    assign pop  = stored_valid && Out_ready;

    assign Count = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= In_pc;
            instr_mem[wr_ptr_reg] <= In_instr;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of queue entries; the value SHALL be a power of two and at least 2.
REQ-002 Parameter IW, default 9, sets the instruction word width in bits.
REQ-003 Parameter AW, default 16, sets the PC width in bits and SHALL match the fetch PC.
REQ-004 Port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-005 Port Init, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port In_valid, input, 1 bit: the fetch side presents an entry.
REQ-007 Port In_pc, input, AW bits: PC of the presented instruction.
REQ-008 Port In_instr, input, IW bits: the presented instruction word.
REQ-009 Port In_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-010 Port Flush, input, 1 bit: discard all entries (taken branch or jump).
REQ-011 Port Out_valid, output, 1 bit: the head entry is valid.
REQ-012 Port Out_pc, output, AW bits: PC of the head entry.
REQ-013 Port Out_instr, output, IW bits: instruction of the head entry.
REQ-014 Port Out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-015 Port Count, output, $clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries of {pc, instr} with write pointer, read pointer and occupancy counter.
REQ-017 A push SHALL occur when In_valid && In_ready; a pop SHALL occur when Out_valid && Out_ready.
REQ-018 In_ready SHALL be 1 when Count < DEPTH && !Flush && !Init, else 0.
REQ-019 Out_valid SHALL be 1 when Count > 0 && !Flush, else 0; Out_pc/Out_instr SHALL show the entry at the read pointer.
REQ-020 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-021 Simultaneous push and pop SHALL leave Count unchanged and advance both pointers.
REQ-022 A push with Count == DEPTH is impossible (In_ready = 0); In_valid while full SHALL be ignored with no state change.
REQ-023 A pop with Count == 0 is impossible (Out_valid = 0); Out_ready while empty SHALL have no effect.
REQ-024 FIFO order SHALL be strict; entries SHALL pop in push order.
REQ-025 Flush SHALL, at the next edge, set Count = 0 and both pointers = 0, overriding any push or pop in that cycle.
REQ-026 The earliest Out_valid after a push into an empty queue SHALL be the following cycle (1-cycle latency) unless REQ-031 applies.
REQ-027 Out_pc and Out_instr SHALL be don't-care while Out_valid = 0.

Reset
REQ-028 When Init = 1 at a rising edge, Count, the write pointer and the read pointer SHALL become 0.
REQ-029 While Init = 1, In_ready and Out_valid SHALL be 0; Init SHALL take priority over Flush, push and pop.
REQ-030 Entry storage SHALL need no reset; a reset mid-operation SHALL discard all entries.

Configuration
REQ-031 With FETCH_QUEUE_BYPASS_EN defined, a cycle with Count == 0 && In_valid && Out_ready && !Flush && !Init SHALL drive Out_valid = 1, Out_pc = In_pc and Out_instr = In_instr combinationally, and the entry SHALL NOT be stored (Count stays 0).
REQ-032 Without FETCH_QUEUE_BYPASS_EN, no combinational path from In_* to Out_* SHALL exist, and the minimum latency SHALL be 1 cycle.

Verification
REQ-033 Init for 2 cycles -> Count=0, Out_valid=0, In_ready=1 on the cycle after Init drops.
REQ-034 Push pc 0..4 (instr 0x100+pc) with Out_ready=0, DEPTH=4 -> Count=4, In_ready=0 after 4 pushes, and pc 4 is held off; then Out_ready=1 -> pops pc 0,1,2,3 in order, then pc 4.
REQ-035 Push and pop every cycle for 10 cycles from Count=2 -> Count stays 2, pointers wrap, and the output sequence matches the input sequence delayed by 2 entries.
REQ-036 Count=3, Flush=1 with In_valid=1 and Out_ready=1 -> In_ready=0, Out_valid=0, Count=0 next cycle, and no push is recorded.
REQ-037 Count=2, Init=1 with In_valid=1 -> Count=0 next cycle and Out_valid=0.
REQ-038 Empty queue, In_valid=1, pc=0x0007, Out_ready=1 -> with FETCH_QUEUE_BYPASS_EN, Out_valid=1 and Out_pc=0x0007 in the same cycle with Count=0; without it, Out_valid=1 and Out_pc=0x0007 next cycle with Count=1.
